dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Memory-stage store path. It is the write-side counterpart of the load formatter in write-back.
- Accepts byte, halfword and word stores from the pipeline and aligns them big-endian into 32-bit word lanes with byte enables.
- Queues aligned stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Flags loads that hit a pending store so the hazard unit can stall.

Parameters:
- DEPTH, 4, store-buffer entries (power of 2, ≥2)
- AW, 32, address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request from memory stage
- st_addr  in  [0:AW-1]  byte address
- st_data  in  [0:31]  register data; the stored value is in the low-order bits
- st_size  in  [0:2]  same encoding as load dmem_info: [1]=word, else [2]=half, else byte; [0] ignored
- st_ready  out  1  buffer can accept (not full)
- misalign  out  1  registered pulse: last offered store was misaligned and dropped
- dmem_req  out  1  write request to data memory
- dmem_addr  out  [0:AW-1]  word-aligned address, bits [AW-2:AW-1]=0
- dmem_wdata  out  [0:31]  lane-aligned data
- dmem_be  out  [0:3]  byte enables; be[k] covers bits [8k:8k+7]
- dmem_ack  in  1  memory accepted the current request
- ld_addr  in  [0:AW-1]  load address in memory stage
- ld_valid  in  1  load present
- ld_hazard  out  1  combinational: load overlaps a pending store
- empty  out  1  no pending stores

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - FIFO pointers and count are 0; empty=1, st_ready=1.
  - dmem_req=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, misalign=0.
  - FSM is in IDLE.
- Reset mid-transaction abandons the in-flight request; the memory must tolerate this.
- Acceptance:
  - A store is accepted when st_valid && st_ready && aligned.
  - st_ready = (count != DEPTH), computed from registered count only.
  - A pop in the same cycle does not free a slot for a push.
- Alignment, with off = st_addr[AW-2:AW-1]:
  - Byte: any off. Lane off gets st_data[24:31]; be is one-hot at off.
  - Half: off 0 or 2. Lanes off and off+1 get st_data[16:31]; be = 1100 (off 0) or 0011 (off 2).
  - Word: off 0 only. wdata = st_data; be = 1111.
- Misaligned store: not enqueued; misalign pulses high for 1 cycle on the next edge.
- Non-enabled lanes of wdata are 0.
- Entry format: {word address, wdata, be}, computed at enqueue. Entries are 1 + DEPTH-1 ... pure FIFO order, no merging.
- Drain FSM:
  - IDLE: if count != 0, load head entry into the dmem_* registers, set dmem_req=1, go to REQ. Earliest request is 1 cycle after enqueue.
  - REQ: hold dmem_req and all dmem_* stable until dmem_ack.
    - On ack: pop head, deassert dmem_req, go to IDLE.
    - Back-to-back: if another entry remains (counting any same-cycle push), load it and stay in REQ with dmem_req=1. This gives 1 store per cycle with ack held high.
  - dmem_ack while in IDLE is ignored.
- Push and pop in the same cycle: count unchanged; both pointers advance; wrap modulo DEPTH.
- ld_hazard:
  - High when ld_valid and any valid entry (including the one in flight) has the same word address as ld_addr and a nonzero be overlap with the load's byte range.
  - The load's byte range uses ld_addr offset and a full-word assumption: all 4 lanes, i.e. a word-address match suffices.
  - A store accepted in the same cycle is not included.
- empty = (count==0) && !dmem_req.

Decomposition:
- Shared package mem_pkg:
  - size encoding constants SZ_WORD_BIT=1, SZ_HALF_BIT=2
  - lane/byte-enable constants BE_ALL=4'b1111
  - entry struct {addr, wdata, be}
- Sub-module store_align: combinational alignment, be generation and misalign detection. It is reusable by a future cache write path.
- FIFO and FSM stay in the top module.

Test Plan:
- Reset → store byte addr 0x103, data 0x000000AB → one request: dmem_addr 0x100, wdata 0x000000AB, be 0001, issued 1 cycle after accept.
- Half addr 0x200, data 0x1234BEEF → wdata 0xBEEF0000, be 1100. Half addr 0x202 → wdata 0x0000BEEF, be 0011.
- Half addr 0x201 → no enqueue, misalign=1 for 1 cycle, dmem_req stays 0. Word addr 0x104 → be 1111, wdata = st_data.
- dmem_ack held 0; push 4 stores → st_ready=0 after the 4th. The 5th st_valid is not accepted. dmem_req and dmem_* stay stable. Then ack=1 for 4 cycles → 4 requests in FIFO order, 1 per cycle; empty=1 after.
- Pending store at 0x100; ld_valid with ld_addr 0x102 → ld_hazard=1. ld_addr 0x104 → 0. After ack drains the store, ld_addr 0x102 → 0.
- Assert rst_n=0 while dmem_req=1 with 3 entries queued → dmem_req=0, empty=1 and st_ready=1 immediately, asynchronously.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path: size encoding,
// byte-enable constants and the aligned lane payload.
package mem_pkg;

   localparam int SZ_WORD_BIT = 1;
   localparam int SZ_HALF_BIT = 2;

   localparam logic [0:3] BE_ALL  = 4'b1111;
   localparam logic [0:3] BE_NONE = 4'b0000;

   // Lane-aligned payload; the word address is carried alongside it in each entry
   typedef struct packed {
      logic [0:31] wdata;
      logic [0:3]  be;
   } lane_t;

endpackage

// File: rtl/store_align.sv
// Combinational big-endian store alignment: places byte/half/word data
// into 32-bit lanes, generates byte enables and flags misaligned stores.
module store_align
   import mem_pkg::*;
(
   input  logic [0:1]  off,
   input  logic [0:31] data,
   input  logic [0:2]  size,
   output logic [0:31] wdata,
   output logic [0:3]  be,
   output logic        misalign
);

   lane_t lane;

   // Lanes that are not enabled stay zero so memory sees clean data
   always_comb begin
      lane     = '0;
      misalign = 1'b0;
      if (size[SZ_WORD_BIT]) begin
         if (off != 2'd0) begin
            misalign = 1'b1;
         end else begin
            lane.wdata = data;
            lane.be    = BE_ALL;
         end
      end else if (size[SZ_HALF_BIT]) begin
         if (off[1]) begin
            misalign = 1'b1;
         end else if (off[0]) begin
            lane.wdata[16:31] = data[16:31];
            lane.be           = 4'b0011;
         end else begin
            lane.wdata[0:15] = data[16:31];
            lane.be          = 4'b1100;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (off == 2'(k)) begin
               lane.wdata[8*k +: 8] = data[24:31];
               lane.be[k]           = 1'b1;
            end
         end
      end
   end

   assign wdata = lane.wdata;
   assign be    = lane.be;

endmodule

// File: rtl/dmem_store_buffer.sv
// Memory-stage store buffer: aligns stores, queues them in a FIFO and drains
// them to data memory over req/ack, flagging loads that hit pending stores.
module dmem_store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          st_valid,
   input  logic [0:AW-1] st_addr,
   input  logic [0:31]   st_data,
   input  logic [0:2]    st_size,
   output logic          st_ready,
   output logic          misalign,
   output logic          dmem_req,
   output logic [0:AW-1] dmem_addr,
   output logic [0:31]   dmem_wdata,
   output logic [0:3]    dmem_be,
   input  logic          dmem_ack,
   input  logic [0:AW-1] ld_addr,
   input  logic          ld_valid,
   output logic          ld_hazard,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic [0:AW-1] addr;
      lane_t         lane;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, next_head;
   logic [PW:0]   count_q, count_d;
   state_t        state_q, state_d;
   logic          req_q, req_d, misalign_q, misalign_d;
   logic [0:AW-1] addr_q, addr_d;
   logic [0:31]   wdata_q, wdata_d;
   logic [0:3]    be_q, be_d;

   logic [0:31]   al_wdata;
   logic [0:3]    al_be;
   logic          al_misalign;
   entry_t        new_entry;
   logic          push, pop;

   store_align u_align (
      .off      (st_addr[AW-2:AW-1]),
      .data     (st_data),
      .size     (st_size),
      .wdata    (al_wdata),
      .be       (al_be),
      .misalign (al_misalign)
   );

   assign new_entry.addr       = {st_addr[0:AW-3], 2'b00};
   assign new_entry.lane.wdata = al_wdata;
   assign new_entry.lane.be    = al_be;

   assign st_ready = (count_q != CNT_FULL);
   assign push     = st_valid && st_ready && !al_misalign;
   assign pop      = (state_q == REQ) && dmem_ack;

   // The in-flight entry stays at the head until acked, so the hazard check sees it
   always_comb begin
      mem_d      = mem_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      state_d    = state_q;
      req_d      = req_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      misalign_d = st_valid && al_misalign;
      next_head  = head_q + PTR_ONE;

      if (push) begin
         mem_d[tail_q] = new_entry;
         tail_d        = tail_q + PTR_ONE;
      end
      if (pop) begin
         head_d = next_head;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               addr_d  = mem_q[head_q].addr;
               wdata_d = mem_q[head_q].lane.wdata;
               be_d    = mem_q[head_q].lane.be;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (dmem_ack) begin
               // With a single entry left, a same-cycle push lands at next_head
               if (count_q > CNT_ONE) begin
                  addr_d  = mem_q[next_head].addr;
                  wdata_d = mem_q[next_head].lane.wdata;
                  be_d    = mem_q[next_head].lane.be;
               end else if (push) begin
                  addr_d  = new_entry.addr;
                  wdata_d = new_entry.lane.wdata;
                  be_d    = new_entry.lane.be;
               end else begin
                  req_d   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         misalign_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         misalign_q <= misalign_d;
      end
   end

   // Loads are treated as full-word, so a word-address match is enough
   logic [0:AW-1] ld_word;
   logic [PW-1:0] rel;
   logic          hazard_c;

   always_comb begin
      ld_word  = {ld_addr[0:AW-3], 2'b00};
      rel      = '0;
      hazard_c = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         rel = PW'(k) - head_q;
         if (ld_valid && ({1'b0, rel} < count_q) &&
             (mem_q[k].addr == ld_word) && (mem_q[k].lane.be != BE_NONE)) begin
            hazard_c = 1'b1;
         end
      end
   end

   assign ld_hazard  = hazard_c;
   assign dmem_req   = req_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign misalign   = misalign_q;
   assign empty      = (count_q == '0) && !req_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: directed stores push expected
// memory requests, a monitor compares them at each req/ack handshake.
module tb_dmem_store_buffer;

   localparam logic [0:2] SZ_B = 3'b000;
   localparam logic [0:2] SZ_H = 3'b001;
   localparam logic [0:2] SZ_W = 3'b010;

   logic        clk;
   logic        rst_n;
   logic        st_valid;
   logic [0:31] st_addr;
   logic [0:31] st_data;
   logic [0:2]  st_size;
   logic        st_ready;
   logic        misalign;
   logic        dmem_req;
   logic [0:31] dmem_addr;
   logic [0:31] dmem_wdata;
   logic [0:3]  dmem_be;
   logic        dmem_ack;
   logic [0:31] ld_addr;
   logic        ld_valid;
   logic        ld_hazard;
   logic        empty;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t expQ[$];
   int   total  = 0;
   int   passed = 0;

   dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .st_size    (st_size),
      .st_ready   (st_ready),
      .misalign   (misalign),
      .dmem_req   (dmem_req),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_ack   (dmem_ack),
      .ld_addr    (ld_addr),
      .ld_valid   (ld_valid),
      .ld_hazard  (ld_hazard),
      .empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [0:2] size, input logic [31:0] eWdata,
                                input logic [3:0] eBe, input bit expectIt);
      exp_t e;
      st_valid = 1'b1;
      st_addr  = addr;
      st_data  = data;
      st_size  = size;
      if (expectIt) begin
         e.addr  = {addr[31:2], 2'b00};
         e.wdata = eWdata;
         e.be    = eBe;
         expQ.push_back(e);
      end
      step();
      st_valid = 1'b0;
   endtask

   task automatic drainAll();
      int n;
      n = 0;
      dmem_ack = 1'b1;
      while (!empty && n < 50) begin
         step();
         n++;
      end
      dmem_ack = 1'b0;
      checkOutput("drain_done", {31'd0, empty}, 32'd1);
      checkOutput("sb_drained", expQ.size(), 32'd0);
   endtask

   // Monitor: a handshake completes on the edge after req && ack is seen here
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && dmem_req && dmem_ack) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_req_addr", dmem_addr, 32'hFFFF_FFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput("req_addr", dmem_addr, e.addr);
               checkOutput("req_wdata", dmem_wdata, e.wdata);
               checkOutput("req_be", {28'd0, dmem_be}, {28'd0, e.be});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_size  = SZ_B;
      dmem_ack = 1'b0;
      ld_addr  = '0;
      ld_valid = 1'b0;
      repeat (2) step();

      checkOutput("rst_empty", {31'd0, empty}, 32'd1);
      checkOutput("rst_st_ready", {31'd0, st_ready}, 32'd1);
      checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
      checkOutput("rst_addr", dmem_addr, 32'd0);
      checkOutput("rst_wdata", dmem_wdata, 32'd0);
      checkOutput("rst_be", {28'd0, dmem_be}, 32'd0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
      rst_n = 1'b1;
      step();

      // Byte store, request one cycle after accept
      applyStimulus(32'h103, 32'h0000_00AB, SZ_B, 32'h0000_00AB, 4'b0001, 1'b1);
      checkOutput("byte_no_req_yet", {31'd0, dmem_req}, 32'd0);
      checkOutput("byte_not_empty", {31'd0, empty}, 32'd0);
      step();
      checkOutput("byte_req_latency", {31'd0, dmem_req}, 32'd1);
      drainAll();

      // Halfwords at both legal offsets
      applyStimulus(32'h200, 32'h1234_BEEF, SZ_H, 32'hBEEF_0000, 4'b1100, 1'b1);
      applyStimulus(32'h202, 32'h1234_BEEF, SZ_H, 32'h0000_BEEF, 4'b0011, 1'b1);
      drainAll();

      // Misaligned half is dropped with a one-cycle pulse
      applyStimulus(32'h201, 32'h1234_BEEF, SZ_H, 32'h0, 4'b0000, 1'b0);
      checkOutput("misalign_pulse", {31'd0, misalign}, 32'd1);
      checkOutput("misalign_empty", {31'd0, empty}, 32'd1);
      step();
      checkOutput("misalign_clear", {31'd0, misalign}, 32'd0);
      checkOutput("misalign_no_req", {31'd0, dmem_req}, 32'd0);

      applyStimulus(32'h104, 32'hCAFE_F00D, SZ_W, 32'hCAFE_F00D, 4'b1111, 1'b1);
      drainAll();

      // Fill the FIFO with ack held low
      applyStimulus(32'h300, 32'h1111_1111, SZ_W, 32'h1111_1111, 4'b1111, 1'b1);
      applyStimulus(32'h304, 32'h2222_2222, SZ_W, 32'h2222_2222, 4'b1111, 1'b1);
      applyStimulus(32'h309, 32'h0000_0055, SZ_B, 32'h0055_0000, 4'b0100, 1'b1);
      applyStimulus(32'h30E, 32'h0000_7777, SZ_H, 32'h0000_7777, 4'b0011, 1'b1);
      checkOutput("full_not_ready", {31'd0, st_ready}, 32'd0);
      applyStimulus(32'h310, 32'h3333_3333, SZ_W, 32'h0, 4'b0000, 1'b0);
      checkOutput("full_still_not_ready", {31'd0, st_ready}, 32'd0);
      checkOutput("full_req_held", {31'd0, dmem_req}, 32'd1);
      checkOutput("full_addr_stable", dmem_addr, 32'h300);
      checkOutput("full_wdata_stable", dmem_wdata, 32'h1111_1111);
      checkOutput("full_be_stable", {28'd0, dmem_be}, 32'hF);
      dmem_ack = 1'b1;
      step();
      checkOutput("b2b_req_1", {31'd0, dmem_req}, 32'd1);
      checkOutput("b2b_ready", {31'd0, st_ready}, 32'd1);
      step();
      checkOutput("b2b_req_2", {31'd0, dmem_req}, 32'd1);
      step();
      checkOutput("b2b_req_3", {31'd0, dmem_req}, 32'd1);
      step();
      dmem_ack = 1'b0;
      checkOutput("b2b_empty", {31'd0, empty}, 32'd1);
      checkOutput("b2b_sb_empty", expQ.size(), 32'd0);

      // Load hazard against a pending store
      applyStimulus(32'h101, 32'h0000_0012, SZ_B, 32'h0012_0000, 4'b0100, 1'b1);
      ld_valid = 1'b1;
      ld_addr  = 32'h102;
      #1;
      checkOutput("haz_queued", {31'd0, ld_hazard}, 32'd1);
      ld_addr = 32'h104;
      #1;
      checkOutput("haz_other_word", {31'd0, ld_hazard}, 32'd0);
      ld_valid = 1'b0;
      ld_addr  = 32'h102;
      #1;
      checkOutput("haz_no_load", {31'd0, ld_hazard}, 32'd0);
      ld_valid = 1'b1;
      step();
      checkOutput("haz_in_flight", {31'd0, ld_hazard}, 32'd1);
      drainAll();
      checkOutput("haz_after_drain", {31'd0, ld_hazard}, 32'd0);
      ld_valid = 1'b0;

      // Reset while a request is outstanding with three entries queued
      applyStimulus(32'h500, 32'hAAAA_AAAA, SZ_W, 32'h0, 4'b0000, 1'b0);
      applyStimulus(32'h504, 32'hBBBB_BBBB, SZ_W, 32'h0, 4'b0000, 1'b0);
      applyStimulus(32'h508, 32'hCCCC_CCCC, SZ_W, 32'h0, 4'b0000, 1'b0);
      checkOutput("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_req", {31'd0, dmem_req}, 32'd0);
      checkOutput("async_rst_empty", {31'd0, empty}, 32'd1);
      checkOutput("async_rst_ready", {31'd0, st_ready}, 32'd1);
      step();
      rst_n = 1'b1;
      step();

      applyStimulus(32'h400, 32'h0000_009A, SZ_B, 32'h9A00_0000, 4'b1000, 1'b1);
      drainAll();

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
